fir_acc_multich: RTL and testbench
==================================

Name: fir_acc_multich

Overview:
- Parametrised, multi-channel successor of the FIR accumulator.
- Sums signed tap products for NCH time-interleaved channels using a valid/ready input handshake with first/last tap markers.
- On the last tap it applies optional rounding, an arithmetic right shift and saturation, then pushes the result into a 2-entry output FIFO with its own valid/ready handshake.
- Sits between the MAC/SpSram read path and the FIR output stage.

Parameters:
- DW, 16, input product width (signed).
- OW, 16, output width (signed).
- NCH, 4, number of interleaved channels.
- NTAP, 10, maximum taps per sum; exceeding it is a protocol error.
- SHIFT, 0, arithmetic right shift applied before saturation (0..DW).
- GW, $clog2(NTAP)+1, guard bits; accumulator width ACCW = DW+GW.

Ports:
- iClk  in  1  rising-edge clock
- iRsn  in  1  reset, asynchronous, active-low
- iClr  in  1  synchronous clear of accumulators, channel states, FIFO and sticky flags
- iRndEn  in  1  round-half-up enable (effective only when SHIFT>0)
- iInVld  in  1  input tap valid
- oInRdy  out  1  input ready
- iInCh  in  max(1,$clog2(NCH))  channel index of the tap
- iInDt  in  DW  signed tap product
- iInFirst  in  1  first tap of a sum
- iInLast  in  1  last tap of a sum
- oOutVld  out  1  FIFO head valid
- iOutRdy  in  1  downstream ready
- oOutCh  out  max(1,$clog2(NCH))  channel of the head result
- oOutDt  out  OW  saturated result
- oOutSat  out  1  head result was saturated
- oErr  out  1  sticky protocol error

Behaviour:
- Reset (iRsn=0, asynchronous):
  - All accumulators and tap counters go to 0.
  - All channels go to IDLE.
  - FIFO is emptied.
  - oOutVld=0, oOutCh=0, oOutDt=0, oOutSat=0, oErr=0, oInRdy=0 while reset is asserted.
- Reset mid-sum discards any partial sums.
- Accept: a tap is accepted when iInVld && oInRdy. oInRdy = !iClr && (FIFO count < 2).
- Per-channel FSM, IDLE / ACC:
  - IDLE + first → acc = sext(iInDt), cnt = 1, go to ACC.
  - IDLE + non-first → treated as first; oErr set.
  - ACC + non-first → acc += sext(iInDt), cnt++.
  - ACC + first → restart from iInDt; oErr set.
  - cnt reaching NTAP without last → oErr set; summing continues (wraps at ACCW).
- Last tap (may coincide with first, giving a single-tap sum):
  - sum = acc_next (ACCW bits).
  - If iRndEn and SHIFT>0: sum += 2^(SHIFT-1).
  - sum >>>= SHIFT.
  - Saturate to [-2^(OW-1), 2^(OW-1)-1] and set the sat flag if clamped.
  - Push {ch, dt, sat} into the FIFO.
  - Channel returns to IDLE; acc=0, cnt=0.
- Latency: the last tap accepted in cycle N gives oOutVld=1 in cycle N+1 when the FIFO was empty.
- FIFO:
  - 2 entries, in-order, first-word fall-through registered outputs.
  - Pop when oOutVld && iOutRdy.
  - Simultaneous push and pop is allowed, with count unchanged. A push is never lost because oInRdy guarantees space.
  - Output fields hold their value while oOutVld && !iOutRdy.
- Channels are independent; results leave in order of their last taps, not in channel order.
- iClr has the same effect as reset, but synchronous; no tap is accepted in the iClr cycle.
- oErr stays set until reset or iClr.

Decomposition:
- Package fir_acc_pkg holds:
  - default parameter constants;
  - a saturation function (ACCW→OW) returning {dt, sat};
  - the channel state typedef (IDLE, ACC).
- One sub-module: fir_acc_out_fifo (2-entry valid/ready FIFO, width OW+1+CHW).

Test Plan:
1. Positive saturation: ch0 taps 0x7000 (first), 0x7000 (last), iOutRdy=1 → next cycle oOutVld=1, oOutCh=0, oOutDt=0x7FFF, oOutSat=1.
2. Negative saturation: ch0 taps 0x8000, 0x8000 → oOutDt=0x8000, oOutSat=1. Then taps 0x0100, 0xFF00 → oOutDt=0x0000, oOutSat=0.
3. Interleave and ordering: ch1 taps 1, 2, interleaved with ch2 taps 10, 20 (last); then ch1 tap 3 (last) → outputs are ch2=30 first, then ch1=6. oErr=0.
4. Backpressure:
   - iOutRdy=0 and two completed sums → oInRdy=0, and a third last tap is held by the source.
   - Raise iOutRdy → three results emerge in order with values unchanged while stalled.
5. Rounding with SHIFT=4, single-tap sums (first=last=1):
   - 0x0018 with iRndEn=1 → 2; with iRndEn=0 → 1.
   - -24 with iRndEn=1 → -1.
6. Protocol and reset:
   - 11 non-last taps on ch3 (NTAP=10) → oErr=1 after the 10th count.
   - Assert iRsn low mid-sum → all outputs 0 immediately.
   - A new sum on ch3 of taps 5, 7 → oOutDt=12, oErr=0.

Source files
------------

// File: rtl/fir_acc_pkg.sv
// Shared defaults, channel state type and output saturation helper for the
// multi-channel FIR accumulator.
package fir_acc_pkg;

  localparam int unsigned DefDw    = 16;
  localparam int unsigned DefOw    = 16;
  localparam int unsigned DefNch   = 4;
  localparam int unsigned DefNtap  = 10;
  localparam int unsigned DefShift = 0;

  typedef enum logic {ChIdle, ChAcc} chState_e;

  function automatic int unsigned chWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a sign-extended value to ow signed bits; returns {dt, sat}.
  function automatic logic [64:0] satFn(input logic signed [63:0] val, input int unsigned ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (val > hi) begin
      return {hi, 1'b1};
    end else if (val < lo) begin
      return {lo, 1'b1};
    end
    return {val, 1'b0};
  endfunction

endpackage

// File: rtl/fir_acc_out_fifo.sv
// Two-entry in-order FIFO with registered first-word fall-through head and
// valid/ready on the read side.
module fir_acc_out_fifo
  import fir_acc_pkg::*;
#(
  parameter int unsigned W = DefOw + 1 + chWidth(DefNch)
) (
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iClr,
  input  logic         iPush,
  input  logic [W-1:0] iPushDt,
  output logic         oFull,
  output logic         oVld,
  input  logic         iRdy,
  output logic [W-1:0] oDt
);

  logic [W-1:0] headQ;
  logic [W-1:0] tailQ;
  logic [1:0]   cntQ;
  logic         pop;

  always_comb begin
    oVld  = (cntQ != 2'd0);
    oFull = (cntQ == 2'd2);
    oDt   = headQ;
    pop   = oVld && iRdy;
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      headQ <= '0;
      tailQ <= '0;
      cntQ  <= 2'd0;
    end else if (iClr) begin
      headQ <= '0;
      tailQ <= '0;
      cntQ  <= 2'd0;
    end else begin
      case (cntQ)
        2'd0: begin
          if (iPush) begin
            headQ <= iPushDt;
            cntQ  <= 2'd1;
          end
        end
        2'd1: begin
          if (iPush && pop) begin
            headQ <= iPushDt;
          end else if (iPush) begin
            tailQ <= iPushDt;
            cntQ  <= 2'd2;
          end else if (pop) begin
            cntQ <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            headQ <= tailQ;
            if (iPush) begin
              tailQ <= iPushDt;
            end else begin
              cntQ <= 2'd1;
            end
          end
        end
        default: cntQ <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/fir_acc_multich.sv
// Multi-channel FIR tap accumulator: per-channel sums with first/last markers,
// round/shift/saturate on the last tap, results queued in a 2-entry FIFO.
module fir_acc_multich
  import fir_acc_pkg::*;
#(
  parameter int unsigned DW    = DefDw,
  parameter int unsigned OW    = DefOw,
  parameter int unsigned NCH   = DefNch,
  parameter int unsigned NTAP  = DefNtap,
  parameter int unsigned SHIFT = DefShift,
  parameter int unsigned GW    = $clog2(NTAP) + 1
) (
  input  logic                     iClk,
  input  logic                     iRsn,
  input  logic                     iClr,
  input  logic                     iRndEn,
  input  logic                     iInVld,
  output logic                     oInRdy,
  input  logic [chWidth(NCH)-1:0]  iInCh,
  input  logic [DW-1:0]            iInDt,
  input  logic                     iInFirst,
  input  logic                     iInLast,
  output logic                     oOutVld,
  input  logic                     iOutRdy,
  output logic [chWidth(NCH)-1:0]  oOutCh,
  output logic [OW-1:0]            oOutDt,
  output logic                     oOutSat,
  output logic                     oErr
);

  localparam int unsigned ACCW = DW + GW;
  localparam int unsigned CHW  = chWidth(NCH);
  localparam int unsigned CNTW = $clog2(NTAP + 1);
  localparam int unsigned FW   = OW + 1 + CHW;
  localparam logic signed [ACCW:0] RndHalf = (ACCW + 1)'((2 ** SHIFT) / 2);

  chState_e               stQ  [NCH];
  logic signed [ACCW-1:0] accQ [NCH];
  logic [CNTW-1:0]        cntQ [NCH];
  logic                   errQ;

  logic                   fifoFull;
  logic                   accept;
  logic                   isStart;
  logic                   errNow;
  logic signed [ACCW-1:0] tapExt;
  logic signed [ACCW-1:0] accNext;
  logic [CNTW-1:0]        cntNext;
  logic signed [ACCW:0]   rndSum;
  logic signed [ACCW:0]   shSum;
  logic [64:0]            satRes;
  logic [64-OW-1:0]       satUnused;
  logic [FW-1:0]          pushDt;
  logic [FW-1:0]          fifoDt;

  always_comb begin
    oInRdy  = iRsn && !iClr && !fifoFull;
    accept  = iInVld && oInRdy;
    tapExt  = {{GW{iInDt[DW-1]}}, iInDt};
    // A non-first tap on an idle channel is taken as the start of a new sum.
    isStart = iInFirst || (stQ[iInCh] == ChIdle);
    accNext = isStart ? tapExt : accQ[iInCh] + tapExt;
    if (isStart) begin
      cntNext = CNTW'(1);
    end else if (cntQ[iInCh] == CNTW'(NTAP)) begin
      cntNext = cntQ[iInCh];
    end else begin
      cntNext = cntQ[iInCh] + CNTW'(1);
    end
    errNow  = accept && (((stQ[iInCh] == ChAcc) == iInFirst) ||
                         (!iInLast && (cntNext >= CNTW'(NTAP))));
    // One extra bit so the rounding offset cannot wrap the sum.
    rndSum  = {accNext[ACCW-1], accNext} + ((iRndEn && (SHIFT > 0)) ? RndHalf : '0);
    shSum   = rndSum >>> SHIFT;
    satRes  = satFn({{(63 - ACCW){shSum[ACCW]}}, shSum}, OW);
    satUnused = satRes[64:OW+1];
    pushDt  = {iInCh, satRes[OW:1], satRes[0]};
    oErr    = errQ;
    {oOutCh, oOutDt, oOutSat} = fifoDt;
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < NCH; i++) begin
        stQ[i]  <= ChIdle;
        accQ[i] <= '0;
        cntQ[i] <= '0;
      end
      errQ <= 1'b0;
    end else if (iClr) begin
      for (int i = 0; i < NCH; i++) begin
        stQ[i]  <= ChIdle;
        accQ[i] <= '0;
        cntQ[i] <= '0;
      end
      errQ <= 1'b0;
    end else begin
      errQ <= errQ | errNow;
      if (accept) begin
        if (iInLast) begin
          stQ[iInCh]  <= ChIdle;
          accQ[iInCh] <= '0;
          cntQ[iInCh] <= '0;
        end else begin
          stQ[iInCh]  <= ChAcc;
          accQ[iInCh] <= accNext;
          cntQ[iInCh] <= cntNext;
        end
      end
    end
  end

  fir_acc_out_fifo #(
    .W(FW)
  ) uOutFifo (
    .iClk   (iClk),
    .iRsn   (iRsn),
    .iClr   (iClr),
    .iPush  (accept && iInLast),
    .iPushDt(pushDt),
    .oFull  (fifoFull),
    .oVld   (oOutVld),
    .iRdy   (iOutRdy),
    .oDt    (fifoDt)
  );

endmodule

// File: tb/tb_fir_acc_multich.sv
// Scoreboard bench: two instances (SHIFT=0 and SHIFT=4) share one stimulus
// stream; a monitor pops expected results computed by a plain-arithmetic model.
module tb_fir_acc_multich;

  localparam int DW   = 16;
  localparam int OW   = 16;
  localparam int NCH  = 4;
  localparam int NTAP = 10;
  localparam int ACCW = DW + $clog2(NTAP) + 1;

  logic          iClk = 1'b0;
  logic          iRsn = 1'b0;
  logic          iClr = 1'b0;
  logic          iRndEn = 1'b0;
  logic          iInVld = 1'b0;
  logic          iInFirst = 1'b0;
  logic          iInLast = 1'b0;
  logic          iOutRdy = 1'b1;
  logic [1:0]    iInCh = '0;
  logic [DW-1:0] iInDt = '0;

  logic          rdy0, vld0, sat0, err0;
  logic          rdy1, vld1, sat1, err1;
  logic [1:0]    ch0, ch1;
  logic [OW-1:0] dt0, dt1;

  always #5 iClk = ~iClk;

  fir_acc_multich #(.DW(DW), .OW(OW), .NCH(NCH), .NTAP(NTAP), .SHIFT(0)) uDut0 (
    .iClk(iClk), .iRsn(iRsn), .iClr(iClr), .iRndEn(iRndEn), .iInVld(iInVld), .oInRdy(rdy0),
    .iInCh(iInCh), .iInDt(iInDt), .iInFirst(iInFirst), .iInLast(iInLast), .oOutVld(vld0),
    .iOutRdy(iOutRdy), .oOutCh(ch0), .oOutDt(dt0), .oOutSat(sat0), .oErr(err0)
  );

  fir_acc_multich #(.DW(DW), .OW(OW), .NCH(NCH), .NTAP(NTAP), .SHIFT(4)) uDut1 (
    .iClk(iClk), .iRsn(iRsn), .iClr(iClr), .iRndEn(iRndEn), .iInVld(iInVld), .oInRdy(rdy1),
    .iInCh(iInCh), .iInDt(iInDt), .iInFirst(iInFirst), .iInLast(iInLast), .oOutVld(vld1),
    .iOutRdy(iOutRdy), .oOutCh(ch1), .oOutDt(dt1), .oOutSat(sat1), .oErr(err1)
  );

  typedef struct {
    int ch;
    int dt;
    bit sat;
  } res_t;

  res_t   q0[$];
  res_t   q1[$];
  int     checks = 0;
  int     errors = 0;
  longint mSum[NCH];
  int     mCnt[NCH];
  bit     mAcc[NCH];
  bit     mErr = 1'b0;
  bit     rdyRand = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Wrap to the accumulator width, round, floor-divide, then clamp.
  function automatic res_t expRes(input int ch, input longint s, input int sh, input bit rnd);
    longint w;
    res_t   r;
    w = s & ((longint'(1) << ACCW) - 1);
    if (w >= (longint'(1) << (ACCW - 1))) w -= (longint'(1) << ACCW);
    if (rnd && sh > 0) w += longint'(1) << (sh - 1);
    w = w >>> sh;
    r.ch  = ch;
    r.sat = 1'b0;
    if (w > 32767) begin
      w = 32767;
      r.sat = 1'b1;
    end else if (w < -32768) begin
      w = -32768;
      r.sat = 1'b1;
    end
    r.dt = int'(w);
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      mSum[i] = 0;
      mCnt[i] = 0;
      mAcc[i] = 1'b0;
    end
    mErr = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic modelTap(input int ch, input longint d, input bit first, input bit last,
                          input bit rnd);
    if (mAcc[ch] == first) mErr = 1'b1;
    if (first || !mAcc[ch]) begin
      mSum[ch] = d;
      mCnt[ch] = 1;
    end else begin
      mSum[ch] += d;
      mCnt[ch]++;
    end
    if (!last && mCnt[ch] >= NTAP) mErr = 1'b1;
    if (last) begin
      q0.push_back(expRes(ch, mSum[ch], 0, rnd));
      q1.push_back(expRes(ch, mSum[ch], 4, rnd));
      mAcc[ch] = 1'b0;
      mSum[ch] = 0;
      mCnt[ch] = 0;
    end else begin
      mAcc[ch] = 1'b1;
    end
  endtask

  // Present one tap and hold it until accepted; returns just after the accepting edge.
  task automatic tap(input int ch, input int d, input bit first, input bit last, input bit rnd);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    iInVld = 1'b1;
    iInCh = ch[1:0];
    iInDt = d[15:0];
    iInFirst = first;
    iInLast = last;
    iRndEn = rnd;
    while (!done) begin
      @(negedge iClk);
      if (rdy0) begin
        modelTap(ch, longint'($signed(iInDt)), first, last, rnd);
        done = 1'b1;
      end
      @(posedge iClk);
      #1;
      n++;
      if (!done && n > 200) begin
        chk("tap_accept_timeout", 0, 1);
        done = 1'b1;
      end
    end
    iInVld = 1'b0;
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_vld0"}, vld0, 0);
    chk({tag, "_ch0"}, ch0, 0);
    chk({tag, "_dt0"}, dt0, 0);
    chk({tag, "_sat0"}, sat0, 0);
    chk({tag, "_err0"}, err0, 0);
    chk({tag, "_rdy0"}, rdy0, 0);
    chk({tag, "_vld1"}, vld1, 0);
    chk({tag, "_ch1"}, ch1, 0);
    chk({tag, "_dt1"}, dt1, 0);
    chk({tag, "_sat1"}, sat1, 0);
    chk({tag, "_err1"}, err1, 0);
    chk({tag, "_rdy1"}, rdy1, 0);
  endtask

  // Scoreboard monitor: compare every popped head against the model queue.
  always @(negedge iClk) begin : monitor
    res_t r;
    if (iRsn) begin
      if (vld0 && iOutRdy) begin
        if (q0.size() == 0) begin
          chk("out0_unexpected", 1, 0);
        end else begin
          r = q0.pop_front();
          chk("out0_ch", ch0, r.ch);
          chk("out0_dt", $signed(dt0), r.dt);
          chk("out0_sat", sat0, r.sat);
        end
      end
      if (vld1 && iOutRdy) begin
        if (q1.size() == 0) begin
          chk("out1_unexpected", 1, 0);
        end else begin
          r = q1.pop_front();
          chk("out1_ch", ch1, r.ch);
          chk("out1_dt", $signed(dt1), r.dt);
          chk("out1_sat", sat1, r.sat);
        end
      end
    end
  end

  initial begin : rdyDriver
    forever begin
      @(posedge iClk);
      #1;
      if (rdyRand) iOutRdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int ch;
    int d;
    int n;
    bit first;
    bit last;

    modelReset();
    #1;
    chkZero("reset");
    repeat (3) @(posedge iClk);
    #1;
    iRsn = 1'b1;
    @(posedge iClk);
    #1;

    // Positive saturation with one-cycle latency.
    tap(0, 'h7000, 1, 0, 0);
    tap(0, 'h7000, 0, 1, 0);
    @(negedge iClk);
    chk("sat_pos_vld", vld0, 1);
    chk("sat_pos_ch", ch0, 0);
    chk("sat_pos_dt", dt0, 'h7FFF);
    chk("sat_pos_sat", sat0, 1);
    @(posedge iClk);
    #1;

    // Negative saturation, then a cancelling pair.
    tap(0, 'h8000, 1, 0, 0);
    tap(0, 'h8000, 0, 1, 0);
    tap(0, 'h0100, 1, 0, 0);
    tap(0, 'hFF00, 0, 1, 0);

    // Interleaved channels complete out of channel order.
    tap(1, 1, 1, 0, 0);
    tap(2, 10, 1, 0, 0);
    tap(1, 2, 0, 0, 0);
    tap(2, 20, 0, 1, 0);
    tap(1, 3, 0, 1, 0);
    repeat (4) @(posedge iClk);
    #1;
    chk("interleave_err", err0, 0);

    // Backpressure: fill the FIFO, hold a third last tap until space frees up.
    iOutRdy = 1'b0;
    tap(0, 100, 1, 1, 0);
    tap(1, 200, 1, 1, 0);
    fork
      tap(2, 300, 1, 1, 0);
      begin
        repeat (3) begin
          @(negedge iClk);
          chk("bp_inrdy", rdy0, 0);
          chk("bp_hold_dt", dt0, 100);
          chk("bp_hold_vld", vld0, 1);
        end
        @(posedge iClk);
        #1;
        iOutRdy = 1'b1;
      end
    join
    repeat (4) @(posedge iClk);
    #1;

    // Rounding with single-tap sums.
    tap(0, 24, 1, 1, 1);
    @(negedge iClk);
    chk("rnd_on_dt1", $signed(dt1), 2);
    @(posedge iClk);
    #1;
    tap(0, 24, 1, 1, 0);
    tap(0, -24, 1, 1, 1);
    repeat (4) @(posedge iClk);
    #1;

    // Tap-count overflow on ch3, then reset mid-sum.
    for (int i = 1; i <= 11; i++) begin
      tap(3, i, i == 1, 0, 0);
      chk("ntap_err0", err0, (i >= NTAP) ? 1 : 0);
      chk("ntap_err1", err1, mErr);
    end
    #2;
    iRsn = 1'b0;
    #1;
    chkZero("midreset");
    modelReset();
    @(posedge iClk);
    #1;
    iRsn = 1'b1;
    tap(3, 5, 1, 0, 0);
    tap(3, 7, 0, 1, 0);
    @(negedge iClk);
    chk("after_reset_dt", dt0, 12);
    chk("after_reset_err", err0, 0);
    @(posedge iClk);
    #1;

    // Randomised traffic with random backpressure and periodic clears.
    rdyRand = 1'b1;
    for (int it = 0; it < 400; it++) begin
      ch = $urandom_range(0, NCH - 1);
      first = !mAcc[ch];
      if ($urandom_range(0, 39) == 0) first = !first;
      last = ($urandom_range(0, 3) == 0) || (mCnt[ch] >= NTAP - 1);
      if (last && $urandom_range(0, 29) == 0) last = 1'b0;
      if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 2000)) - 1000;
      else d = int'($urandom_range(0, 65535)) - 32768;
      tap(ch, d, first, last, $urandom_range(0, 1) == 1);
      chk("rand_err", err0, mErr);
      if (it % 100 == 99) begin
        iClr = 1'b1;
        @(posedge iClk);
        #1;
        iClr = 1'b0;
        modelReset();
        chk("clr_err", err0, 0);
        chk("clr_vld", vld0, 0);
      end
    end
    rdyRand = 1'b0;
    @(posedge iClk);
    #2;
    iOutRdy = 1'b1;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(posedge iClk);
      n++;
    end
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("final_err", err0, mErr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
